prog_sequencer: RTL and testbench
=================================

# prog_sequencer

Multi-cycle instruction sequencer for the 9-bit-instruction processor. Owns the program counter and start/done handshake, and steps each instruction through fetch, execute and (for loads) a memory wait. It gates the control decoder's RegWrite/MemWrite so register-file and data-memory writes occur exactly once, in the correct cycle. Sits between the top level and the instruction ROM, decoder, register file and data memory.

## Interface
- PC_W, 10, program counter width (instruction ROM depth 2^PC_W)
- OP_W, 3, opcode field width (instruction bits [8:6])
- CNT_W, 16, width of performance counters (only with counters compiled in)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle request to run a program
- start_addr  in  PC_W  first instruction address, sampled when start is accepted
- opcode  in  OP_W  opcode of the instruction currently held in the instruction register
- halt  in  1  decoder flag: current instruction is the halt encoding
- branch_taken  in  1  ALU compare result (operands not equal), valid in EXEC
- branch_target  in  PC_W  resolved branch destination, valid in EXEC
- pc  out  PC_W  instruction ROM address
- instr_en  out  1  load enable for the instruction register
- reg_we_en  out  1  qualifier ANDed with decoder RegWrite
- mem_we_en  out  1  qualifier ANDed with decoder MemWrite
- busy  out  1  program running
- done  out  1  program halted; held until next accepted start
- cycle_cnt  out  CNT_W  cycles spent busy (only with counters compiled in)
- instr_cnt  out  CNT_W  instructions retired (only with counters compiled in)

## Operation
- States: IDLE, FETCH, EXEC, MEMWAIT, DONE.
- IDLE: start=1 -> pc<=start_addr, done<=0, go FETCH. Otherwise stay.
- FETCH: instr_en=1 (ROM is synchronous read; IR captures at end of cycle). -> EXEC.
- EXEC, by priority:
  - halt=1 -> DONE; no writes, pc unchanged.
  - opcode 011 (load) -> MEMWAIT; no writes this cycle.
  - opcode 110 (BNE): branch_taken=1 -> pc<=branch_target, else pc<=pc+1; reg_we_en=0, mem_we_en=0; -> FETCH.
  - all other opcodes (000 add, 001 rotate, 010 NAND, 100 store, 101 move, 111 set): reg_we_en=1, mem_we_en=1 for this one cycle; pc<=pc+1; -> FETCH.
- MEMWAIT: reg_we_en=1 (data memory read data valid); pc<=pc+1; -> FETCH.
- DONE: done=1, busy=0. start=1 -> behaves as IDLE accept (pc<=start_addr, done<=0, -> FETCH).
- busy=1 in FETCH, EXEC, MEMWAIT.
- start while busy: ignored.
- pc+1 is modulo 2^PC_W: pc=2^PC_W-1 wraps to 0; no error.
- Branch target is used as given; no range check.

## Timing
- Reset (any state, including mid-instruction): state IDLE, pc=0, instr_en=0, reg_we_en=0, mem_we_en=0, busy=0, done=0, counters 0. Any write qualifier active in the reset cycle is deasserted in the next cycle.
- start accepted at edge N -> pc=start_addr, instr_en=1 in cycle N+1.
- Latency per instruction: 2 cycles (FETCH+EXEC) non-load, 3 cycles load, 2 cycles halt (then done=1 the following cycle).
- reg_we_en/mem_we_en are never high for more than one consecutive cycle per instruction and never in FETCH.
- All outputs registered-state decodes (Moore); branch_taken/halt/opcode sampled only in EXEC.

## Configuration
- PROG_SEQ_PERF_CNT_EN defined: cycle_cnt increments each busy cycle; instr_cnt increments on every EXEC-to-FETCH and MEMWAIT-to-FETCH transition (halt not counted); both clear on accepted start, saturate at 2^CNT_W-1, hold in DONE/IDLE.
- Not defined: cycle_cnt and instr_cnt ports and logic absent.

## Structure
- Shared package prog_seq_pkg: state enum (IDLE, FETCH, EXEC, MEMWAIT, DONE), opcode localparams (OP_ADD 000 ... OP_LOAD 011, OP_STORE 100, OP_BNE 110, OP_SET 111).
- One sub-module: sat_counter (parameter CNT_W; clr, inc, count), instantiated twice under the macro.

## Test plan
- Reset then start=1, start_addr=5; ROM[5]=add, ROM[6]=halt -> pc 5,5,6,6; reg_we_en high exactly at the EXEC of addr 5; done=1 on cycle 5 after start; instr_cnt=1, cycle_cnt=4.
- Load at addr 0 -> FETCH, EXEC, MEMWAIT; reg_we_en high only in MEMWAIT; pc=1 on the next FETCH.
- BNE at addr 3 with branch_taken=1, target=20 -> next pc=20; with branch_taken=0 -> pc=4; no write qualifiers either way.
- start_addr=1023, ROM[1023]=store -> mem_we_en one cycle; next pc=0.
- Assert reset during MEMWAIT -> next cycle IDLE, pc=0, all qualifiers 0; start pulsed while busy -> ignored, pc sequence unchanged.
- From DONE, start=1, start_addr=8 -> done drops next cycle, pc=8, counters cleared.

Source files
------------

// File: rtl/prog_seq_pkg.sv
// rtl/prog_seq_pkg.sv - shared types and opcode constants for the instruction sequencer
//
// Purpose: sequencer state encoding, the 3-bit opcode map of the 9-bit-instruction
// processor, and a helper that classifies opcodes that retire with a write.
// Ports: none (package).

package prog_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    EXEC    = 3'd2,
    MEMWAIT = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_ROT   = 3'b001;
  localparam logic [2:0] OP_NAND  = 3'b010;
  localparam logic [2:0] OP_LOAD  = 3'b011;
  localparam logic [2:0] OP_STORE = 3'b100;
  localparam logic [2:0] OP_MOVE  = 3'b101;
  localparam logic [2:0] OP_BNE   = 3'b110;
  localparam logic [2:0] OP_SET   = 3'b111;

  // Opcodes whose single EXEC cycle opens both write qualifiers; the decoder's
  // RegWrite/MemWrite pick which write actually happens.
  function automatic logic op_writes_in_exec(input logic [2:0] op);
    case (op)
      OP_ADD, OP_ROT, OP_NAND, OP_STORE, OP_MOVE, OP_SET: op_writes_in_exec = 1'b1;
      default:                                             op_writes_in_exec = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose: counts inc pulses, sticks at all-ones, clears on clr or reset.
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset
//   clr    in   synchronous clear (wins over inc)
//   inc    in   count enable
//   count  out  CNT_W current value

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - multi-cycle fetch/execute sequencer for the 9-bit-instruction processor
//
// Purpose: owns the program counter and start/done handshake, steps each
// instruction through FETCH, EXEC and (loads only) MEMWAIT, and gates the
// decoder's RegWrite/MemWrite so each write happens exactly once.
// Optional feature macro: PROG_SEQ_PERF_CNT_EN adds cycle_cnt/instr_cnt.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, start_addr   run request and first instruction address
//   opcode, halt        decoded fields of the instruction register (used in EXEC)
//   branch_taken/target BNE resolution from the ALU (used in EXEC)
//   pc                  instruction ROM address
//   instr_en            instruction register load enable (FETCH)
//   reg_we_en/mem_we_en write qualifiers ANDed with decoder RegWrite/MemWrite
//   busy, done          running / halted status
//   cycle_cnt/instr_cnt busy cycles and retired instructions (macro only)

module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int PC_W = 10,
  parameter int OP_W = 3
`ifdef PROG_SEQ_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  start_addr,
  input  logic [OP_W-1:0]  opcode,
  input  logic             halt,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  output logic [PC_W-1:0]  pc,
  output logic             instr_en,
  output logic             reg_we_en,
  output logic             mem_we_en,
  output logic             busy,
  output logic             done
`ifdef PROG_SEQ_PERF_CNT_EN
  , output logic [CNT_W-1:0] cycle_cnt
  , output logic [CNT_W-1:0] instr_cnt
`endif
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_instr_en;
  logic            w_reg_we;
  logic            w_mem_we;

  // Natural wrap at 2^PC_W - 1 back to 0.
  assign w_pc_inc = r_pc + PC_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_en  = 1'b0;
    w_reg_we    = 1'b0;
    w_mem_we    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_pc_nxt    = start_addr;
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        // ROM read is synchronous; the IR captures at the end of this cycle.
        w_instr_en  = 1'b1;
        w_state_nxt = EXEC;
      end
      EXEC: begin
        if (halt) begin
          w_state_nxt = DONE;
        end else if (opcode == OP_LOAD) begin
          // Write is deferred until read data is valid in MEMWAIT.
          w_state_nxt = MEMWAIT;
        end else if (opcode == OP_BNE) begin
          w_pc_nxt    = branch_taken ? branch_target : w_pc_inc;
          w_state_nxt = FETCH;
        end else begin
          w_reg_we    = op_writes_in_exec(opcode);
          w_mem_we    = op_writes_in_exec(opcode);
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = FETCH;
        end
      end
      MEMWAIT: begin
        w_reg_we    = 1'b1;
        w_pc_nxt    = w_pc_inc;
        w_state_nxt = FETCH;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign pc        = r_pc;
  assign instr_en  = w_instr_en;
  assign reg_we_en = w_reg_we;
  assign mem_we_en = w_mem_we;
  assign busy      = (r_state == FETCH) || (r_state == EXEC) || (r_state == MEMWAIT);
  assign done      = (r_state == DONE);

`ifdef PROG_SEQ_PERF_CNT_EN
  logic w_start_acc;
  logic w_retire;

  assign w_start_acc = ((r_state == IDLE) || (r_state == DONE)) && start;
  // Halt leaves EXEC for DONE, so it never counts as retired.
  assign w_retire    = ((r_state == EXEC) && (w_state_nxt == FETCH)) || (r_state == MEMWAIT);

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_start_acc),
    .inc   (busy),
    .count (cycle_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_start_acc),
    .inc   (w_retire),
    .count (instr_cnt)
  );
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - self-checking bench for prog_sequencer (PROG_SEQ_PERF_CNT_EN aware)

module tb_prog_sequencer;
  import prog_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] start_addr;
  logic [2:0] opcode;
  logic       halt;
  logic       branch_taken;
  logic [9:0] branch_target;
  logic [9:0] pc;
  logic       instr_en;
  logic       reg_we_en;
  logic       mem_we_en;
  logic       busy;
  logic       done;
`ifdef PROG_SEQ_PERF_CNT_EN
  logic [15:0] cycle_cnt;
  logic [15:0] instr_cnt;
`endif

  prog_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .start_addr    (start_addr),
    .opcode        (opcode),
    .halt          (halt),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .instr_en      (instr_en),
    .reg_we_en     (reg_we_en),
    .mem_we_en     (mem_we_en),
    .busy          (busy),
    .done          (done)
`ifdef PROG_SEQ_PERF_CNT_EN
    , .cycle_cnt   (cycle_cnt)
    , .instr_cnt   (instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Program image: per-address opcode, halt flag and branch resolution.
  logic [2:0] rom_op  [1024];
  logic       rom_halt[1024];
  logic       rom_bt  [1024];
  logic [9:0] rom_tgt [1024];

  typedef struct packed {
    logic [9:0] pc;
    logic       ie;
    logic       rwe;
    logic       mwe;
    logic       bsy;
    logic       dn;
  } cyc_t;

  cyc_t trace[$];
  int   exp_retired;
  int   exp_busy;
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 1024; a++) begin
      rom_op[a]   = OP_SET;
      rom_halt[a] = 1'b1;
      rom_bt[a]   = 1'b0;
      rom_tgt[a]  = '0;
    end
  endtask

  task automatic put(input int a, input logic [2:0] op, input logic h, input logic bt, input logic [9:0] tgt);
    rom_op[a]   = op;
    rom_halt[a] = h;
    rom_bt[a]   = bt;
    rom_tgt[a]  = tgt;
  endtask

  // Instruction-level interpreter: expands each instruction into its
  // per-cycle outputs, then appends the final DONE cycle.
  task automatic build_trace(input logic [9:0] a0);
    logic [9:0] a;
    a = a0;
    trace.delete();
    exp_retired = 0;
    for (int k = 0; k < 300; k++) begin
      trace.push_back({a, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
      if (rom_halt[a]) begin
        trace.push_back({a, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        break;
      end
      exp_retired++;
      if (rom_op[a] == OP_LOAD) begin
        trace.push_back({a, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        trace.push_back({a, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        a = a + 10'd1;
      end else if (rom_op[a] == OP_BNE) begin
        trace.push_back({a, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        a = rom_bt[a] ? rom_tgt[a] : a + 10'd1;
      end else begin
        trace.push_back({a, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
        a = a + 10'd1;
      end
    end
    trace.push_back({a, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    exp_busy = trace.size() - 1;
  endtask

  // Called at a negedge with the DUT idle or done.
  task automatic run_program(input string tag, input logic [9:0] a0, input int inject_at);
    cyc_t e;
    build_trace(a0);
    start      = 1'b1;
    start_addr = a0;
    @(negedge clk);
    start      = 1'b0;
    start_addr = ~a0;
    for (int i = 0; i < trace.size(); i++) begin
      e = trace[i];
      chk($sformatf("%s c%0d pc", tag, i), 32'(pc), 32'(e.pc));
      chk($sformatf("%s c%0d instr_en", tag, i), 32'(instr_en), 32'(e.ie));
      chk($sformatf("%s c%0d reg_we_en", tag, i), 32'(reg_we_en), 32'(e.rwe));
      chk($sformatf("%s c%0d mem_we_en", tag, i), 32'(mem_we_en), 32'(e.mwe));
      chk($sformatf("%s c%0d busy", tag, i), 32'(busy), 32'(e.bsy));
      chk($sformatf("%s c%0d done", tag, i), 32'(done), 32'(e.dn));
`ifdef PROG_SEQ_PERF_CNT_EN
      if (i == 0) begin
        chk($sformatf("%s cycle_cnt cleared", tag), 32'(cycle_cnt), 32'd0);
        chk($sformatf("%s instr_cnt cleared", tag), 32'(instr_cnt), 32'd0);
      end
`endif
      if (instr_en) begin
        opcode        = rom_op[pc];
        halt          = rom_halt[pc];
        branch_taken  = rom_bt[pc];
        branch_target = rom_tgt[pc];
      end
      if (i == inject_at && i < trace.size() - 1) begin
        start      = 1'b1;
        start_addr = 10'h2AA;
      end else begin
        start      = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk($sformatf("%s done held", tag), 32'(done), 32'd1);
`ifdef PROG_SEQ_PERF_CNT_EN
    chk($sformatf("%s cycle_cnt", tag), 32'(cycle_cnt), 32'(exp_busy));
    chk($sformatf("%s instr_cnt", tag), 32'(instr_cnt), 32'(exp_retired));
`endif
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " pc"}, 32'(pc), 32'd0);
    chk({tag, " instr_en"}, 32'(instr_en), 32'd0);
    chk({tag, " reg_we_en"}, 32'(reg_we_en), 32'd0);
    chk({tag, " mem_we_en"}, 32'(mem_we_en), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
`ifdef PROG_SEQ_PERF_CNT_EN
    chk({tag, " cycle_cnt"}, 32'(cycle_cnt), 32'd0);
    chk({tag, " instr_cnt"}, 32'(instr_cnt), 32'd0);
`endif
  endtask

  initial begin
    int base;
    int len;
    logic [9:0] ad;
    reset         = 1'b1;
    start         = 1'b0;
    start_addr    = '0;
    opcode        = OP_ADD;
    halt          = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    clear_rom();
    repeat (2) @(negedge clk);
    chk_idle("reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("idle no start");

    // add then halt from address 5
    put(5, OP_ADD, 1'b0, 1'b0, 10'd0);
    run_program("add_halt", 10'd5, -1);

    // load at 0
    clear_rom();
    put(0, OP_LOAD, 1'b0, 1'b0, 10'd0);
    run_program("load", 10'd0, -1);

    // BNE taken, with a start pulse while busy
    clear_rom();
    put(3, OP_BNE, 1'b0, 1'b1, 10'd20);
    run_program("bne_taken", 10'd3, 1);

    // BNE not taken
    put(3, OP_BNE, 1'b0, 1'b0, 10'd20);
    run_program("bne_not_taken", 10'd3, 2);

    // store at the top address wraps pc to 0
    clear_rom();
    put(1023, OP_STORE, 1'b0, 1'b0, 10'd0);
    run_program("store_wrap", 10'd1023, -1);

    // restart from DONE
    clear_rom();
    put(8, OP_SET, 1'b0, 1'b0, 10'd0);
    put(9, OP_MOVE, 1'b0, 1'b0, 10'd0);
    run_program("restart", 10'd8, 0);

    // reset during MEMWAIT
    clear_rom();
    put(40, OP_LOAD, 1'b0, 1'b0, 10'd0);
    start      = 1'b1;
    start_addr = 10'd40;
    @(negedge clk);
    start         = 1'b0;
    opcode        = rom_op[40];
    halt          = rom_halt[40];
    branch_taken  = rom_bt[40];
    branch_target = rom_tgt[40];
    @(negedge clk);
    @(negedge clk);
    chk("memwait reg_we_en", 32'(reg_we_en), 32'd1);
    chk("memwait pc", 32'(pc), 32'd40);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("reset in memwait");
    reset = 1'b0;
    @(negedge clk);
    chk_idle("after reset release");

    // random forward-branching programs, some wrapping past 1023
    for (int r = 0; r < 25; r++) begin
      clear_rom();
      base = int'($urandom_range(0, 1023));
      len  = int'($urandom_range(3, 15));
      for (int j = 0; j < len; j++) begin
        ad = 10'(base + j);
        rom_op[ad]   = 3'($urandom_range(0, 7));
        rom_halt[ad] = ($urandom_range(0, 11) == 0);
        rom_bt[ad]   = 1'($urandom_range(0, 1));
        rom_tgt[ad]  = 10'(base + int'($urandom_range(j + 1, len)));
      end
      run_program($sformatf("rand%0d", r), 10'(base), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout tests_run=%0d", tests_run);
    $fatal(1, "timeout");
  end

endmodule
